apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter STRB_WIDTH, default 4, write strobe width (DATA_WIDTH/8).
REQ-004 SHALL have parameter SLAVES_NUM, default 8, number of PSEL lines.
REQ-005 PCLK  in  1  single clock; all logic on rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous, active-low.
REQ-007 Transfer  in  1  user request to perform transfer(s).
REQ-008 IN_ADDR  in  ADDRESS_WIDTH  user address.
REQ-009 IN_DATA  in  DATA_WIDTH  user write data.
REQ-010 IN_WRITE  in  1  1 = write, 0 = read.
REQ-011 IN_PROT  in  3  user protection attributes.
REQ-012 IN_STRB  in  STRB_WIDTH  user byte strobes.
REQ-013 PRDATA  in  DATA_WIDTH  slave read data.
REQ-014 PREADY  in  1  slave ready.
REQ-015 PSLVERR  in  1  slave error.
REQ-016 PADDR  out  ADDRESS_WIDTH; PWDATA  out  DATA_WIDTH; PWRITE  out  1; PPROT  out  3; PSTRB  out  STRB_WIDTH; APB request signals, registered.
REQ-017 PSEL  out  SLAVES_NUM  one-hot slave select.
REQ-018 PENABLE  out  1  APB access phase.
REQ-019 OUT_RDATA  out  DATA_WIDTH  captured read data; OUT_SLVERR  out  1  captured slave error.

Function
REQ-020 SHALL implement FSM IDLE, SETUP, ACCESS.
REQ-021 IDLE: Transfer=1 -> SETUP, else stay; PSEL=0, PENABLE=0.
REQ-022 SETUP: unconditionally -> ACCESS after one cycle; PSEL one-hot, PENABLE=0.
REQ-023 ACCESS: PENABLE=1, PSEL held; PREADY=0 -> stay (wait state, unlimited); PREADY=1 and Transfer=1 -> SETUP; PREADY=1 and Transfer=0 -> IDLE.
REQ-024 PADDR, PWDATA, PWRITE, PPROT, PSTRB, PSEL SHALL load from user inputs on every rising edge whose next state is SETUP or whose current state is SETUP; they SHALL hold constant while in ACCESS and in IDLE.
REQ-025 PSEL decode SHALL be one-hot: bit index = IN_ADDR[28:26] (0xBAB84CD3 -> 8'b0100_0000; 0xB6B84CD3 -> 8'b0010_0000).
REQ-026 PSTRB SHALL be IN_STRB for writes and all-zero for reads.
REQ-027 On the edge that ends ACCESS with PREADY=1 and PWRITE=0, OUT_RDATA SHALL capture PRDATA; OUT_RDATA holds otherwise (unchanged by writes).
REQ-028 On any edge ending ACCESS with PREADY=1, OUT_SLVERR SHALL capture PSLVERR; holds otherwise.
REQ-029 Back-to-back transfers SHALL have exactly one SETUP cycle (PENABLE=0) between ACCESS phases; minimum transfer = 2 cycles.
REQ-030 Transfer deasserting during SETUP or ACCESS SHALL NOT abort the current transfer; it only prevents the next one.
REQ-031 PREADY/PSLVERR/PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-032 PRESETn=0 SHALL immediately force state IDLE and all outputs (PADDR, PWDATA, PWRITE, PPROT, PSTRB, PSEL, PENABLE, OUT_RDATA, OUT_SLVERR) to 0, including mid-transfer.
REQ-033 After PRESETn rises, first SETUP SHALL occur no earlier than the first rising edge with Transfer=1.

Structure
REQ-034 FSM state encoding (IDLE/SETUP/ACCESS) and PSEL field position (bits 28:26) SHALL be defined in a shared package apb_pkg.
REQ-035 One sub-module apb_psel_decoder (address -> one-hot PSEL) is natural; all else in apb_master.

Verification
REQ-036 Write no-wait: Transfer=1, IN_WRITE=1, addr 0xBAB84CD3, data 98, PREADY=1 in ACCESS -> SETUP shows PSEL=0x40, PADDR=0xBAB84CD3, PWDATA=98; next cycle PENABLE=1; then PENABLE=0.
REQ-037 Back-to-back write: Transfer held, second addr 0xB6B84CD3 data 90 -> SETUP with PSEL=0x20, PWDATA=90; Transfer dropped -> IDLE, PSEL=0, PENABLE=0.
REQ-038 Write with waits: PREADY=0 for 3 cycles in ACCESS -> PENABLE stays 1, PADDR/PWDATA stable; PREADY=1 -> completes.
REQ-039 Read no-wait/with-wait: PRDATA=98 then 90 with PREADY=1 -> OUT_RDATA=98 then 90, PENABLE=0 afterwards, PSTRB=0.
REQ-040 PSLVERR=1 with PREADY=1 -> OUT_SLVERR=1; reset asserted during ACCESS -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared definitions for the APB master: FSM state encoding
//                and the address bit field that selects the target slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_SETUP  = 2'd1;
    localparam state_t c_ST_ACCESS = 2'd2;

    // Address bits carrying the slave index
    localparam int c_PSEL_LSB     = 26;
    localparam int c_PSEL_MSB     = 28;
    localparam int c_PSEL_FIELD_W = c_PSEL_MSB - c_PSEL_LSB + 1;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_psel_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : apb_psel_decoder
//  Description : Turns the slave-index field of an address into a one-hot
//                PSEL vector.
//  Ports       : i_sel_field - slave index taken from the address
//                o_psel      - one-hot slave select
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_psel_decoder
    import apb_pkg::*;
#(
    parameter int SLAVES_NUM = 8
) (
    input  logic [c_PSEL_FIELD_W-1:0] i_sel_field,
    output logic [SLAVES_NUM-1:0]     o_psel
);

    localparam logic [SLAVES_NUM-1:0] c_ONE = {{(SLAVES_NUM-1){1'b0}}, 1'b1};

    // An index past the last slave shifts the bit out, selecting nobody.
    assign o_psel = c_ONE << i_sel_field;

endmodule : apb_psel_decoder
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : APB master. Turns user transfer requests into
//                IDLE -> SETUP -> ACCESS bus cycles, supports unlimited wait
//                states and back-to-back transfers, and captures read data
//                and slave error at the end of each access.
//  Ports       : PCLK, PRESETn          - clock, async active-low reset
//                Transfer, IN_*         - user request and its attributes
//                PRDATA, PREADY, PSLVERR- slave response
//                PADDR..PSTRB, PSEL,
//                PENABLE                - APB request (all registered)
//                OUT_RDATA, OUT_SLVERR  - captured read data / slave error
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int SLAVES_NUM    = 8
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     Transfer,
    input  logic [ADDRESS_WIDTH-1:0] IN_ADDR,
    input  logic [DATA_WIDTH-1:0]    IN_DATA,
    input  logic                     IN_WRITE,
    input  logic [2:0]               IN_PROT,
    input  logic [STRB_WIDTH-1:0]    IN_STRB,
    input  logic [DATA_WIDTH-1:0]    PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    output logic [ADDRESS_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0]    PWDATA,
    output logic                     PWRITE,
    output logic [2:0]               PPROT,
    output logic [STRB_WIDTH-1:0]    PSTRB,
    output logic [SLAVES_NUM-1:0]    PSEL,
    output logic                     PENABLE,
    output logic [DATA_WIDTH-1:0]    OUT_RDATA,
    output logic                     OUT_SLVERR
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_load;
    logic                     w_access_done;
    logic [SLAVES_NUM-1:0]    w_psel_dec;

    logic [ADDRESS_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0]    r_pwdata;
    logic                     r_pwrite;
    logic [2:0]               r_pprot;
    logic [STRB_WIDTH-1:0]    r_pstrb;
    logic [SLAVES_NUM-1:0]    r_psel;
    logic                     r_penable;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_slverr;

    apb_psel_decoder #(
        .SLAVES_NUM (SLAVES_NUM)
    ) u_psel_decoder (
        .i_sel_field (IN_ADDR[c_PSEL_MSB:c_PSEL_LSB]),
        .o_psel      (w_psel_dec)
    );

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (Transfer) w_next_state = c_ST_SETUP;
            c_ST_SETUP:  w_next_state = c_ST_ACCESS;
            c_ST_ACCESS: if (PREADY) w_next_state = Transfer ? c_ST_SETUP : c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Request fields follow the user inputs while entering or sitting in
    // SETUP, and are frozen through ACCESS and IDLE.
    assign w_load        = (w_next_state == c_ST_SETUP) || (r_state == c_ST_SETUP);
    assign w_access_done = (r_state == c_ST_ACCESS) && PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= c_ST_IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_pprot   <= '0;
            r_pstrb   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_penable <= (w_next_state == c_ST_ACCESS);

            if (w_load) begin
                r_paddr  <= IN_ADDR;
                r_pwdata <= IN_DATA;
                r_pwrite <= IN_WRITE;
                r_pprot  <= IN_PROT;
                r_pstrb  <= IN_WRITE ? IN_STRB : '0;
                r_psel   <= w_psel_dec;
            end else if (w_next_state == c_ST_IDLE) begin
                // Bus released: deselect every slave.
                r_psel   <= '0;
            end

            if (w_access_done) begin
                r_slverr <= PSLVERR;
                if (!r_pwrite) r_rdata <= PRDATA;
            end
        end
    end

    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
    assign PWRITE     = r_pwrite;
    assign PPROT      = r_pprot;
    assign PSTRB      = r_pstrb;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign OUT_RDATA  = r_rdata;
    assign OUT_SLVERR = r_slverr;

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Directed self-checking bench for apb_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        Transfer;
    logic [31:0] IN_ADDR;
    logic [31:0] IN_DATA;
    logic        IN_WRITE;
    logic [2:0]  IN_PROT;
    logic [3:0]  IN_STRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
    logic [7:0]  PSEL;
    logic        PENABLE;
    logic [31:0] OUT_RDATA;
    logic        OUT_SLVERR;

    int total = 0;
    int bad   = 0;

    apb_master #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .STRB_WIDTH    (4),
        .SLAVES_NUM    (8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .Transfer   (Transfer),
        .IN_ADDR    (IN_ADDR),
        .IN_DATA    (IN_DATA),
        .IN_WRITE   (IN_WRITE),
        .IN_PROT    (IN_PROT),
        .IN_STRB    (IN_STRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PPROT      (PPROT),
        .PSTRB      (PSTRB),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .OUT_RDATA  (OUT_RDATA),
        .OUT_SLVERR (OUT_SLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_paddr"},   64'(PADDR),      64'h0);
        chk({tag, "_pwdata"},  64'(PWDATA),     64'h0);
        chk({tag, "_pwrite"},  64'(PWRITE),     64'h0);
        chk({tag, "_pprot"},   64'(PPROT),      64'h0);
        chk({tag, "_pstrb"},   64'(PSTRB),      64'h0);
        chk({tag, "_psel"},    64'(PSEL),       64'h0);
        chk({tag, "_penable"}, 64'(PENABLE),    64'h0);
        chk({tag, "_rdata"},   64'(OUT_RDATA),  64'h0);
        chk({tag, "_slverr"},  64'(OUT_SLVERR), 64'h0);
    endtask

    initial begin
        PRESETn  = 1'b0;
        Transfer = 1'b0;
        IN_ADDR  = '0;
        IN_DATA  = '0;
        IN_WRITE = 1'b0;
        IN_PROT  = '0;
        IN_STRB  = '0;
        PRDATA   = '0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        chk_all_zero("reset");
        PRESETn = 1'b1;
        tick();
        chk("idle_no_transfer_psel", 64'(PSEL), 64'h0);
        chk("idle_no_transfer_penable", 64'(PENABLE), 64'h0);

        // ---------------- write, no wait, then back-to-back ----------------
        Transfer = 1'b1;
        IN_WRITE = 1'b1;
        IN_ADDR  = 32'hBAB8_4CD3;
        IN_DATA  = 32'd98;
        IN_PROT  = 3'b010;
        IN_STRB  = 4'hF;
        tick();                                   // SETUP
        chk("w1_setup_psel",    64'(PSEL),    64'h40);
        chk("w1_setup_paddr",   64'(PADDR),   64'hBAB8_4CD3);
        chk("w1_setup_pwdata",  64'(PWDATA),  64'd98);
        chk("w1_setup_penable", 64'(PENABLE), 64'h0);
        chk("w1_setup_pwrite",  64'(PWRITE),  64'h1);
        chk("w1_setup_pprot",   64'(PPROT),   64'h2);
        chk("w1_setup_pstrb",   64'(PSTRB),   64'hF);
        tick();                                   // ACCESS
        chk("w1_access_penable", 64'(PENABLE), 64'h1);
        chk("w1_access_psel",    64'(PSEL),    64'h40);
        IN_ADDR = 32'hB6B8_4CD3;
        IN_DATA = 32'd90;
        PREADY  = 1'b1;
        tick();                                   // SETUP of second write
        chk("w2_setup_psel",    64'(PSEL),    64'h20);
        chk("w2_setup_pwdata",  64'(PWDATA),  64'd90);
        chk("w2_setup_paddr",   64'(PADDR),   64'hB6B8_4CD3);
        chk("w2_setup_penable", 64'(PENABLE), 64'h0);
        Transfer = 1'b0;                          // must not abort this one
        tick();                                   // ACCESS
        chk("w2_access_penable", 64'(PENABLE), 64'h1);
        chk("w2_access_psel",    64'(PSEL),    64'h20);
        tick();                                   // IDLE
        chk("w2_idle_psel",    64'(PSEL),      64'h0);
        chk("w2_idle_penable", 64'(PENABLE),   64'h0);
        chk("w2_idle_paddr",   64'(PADDR),     64'hB6B8_4CD3);
        chk("w2_idle_rdata",   64'(OUT_RDATA), 64'h0);
        tick();
        chk("idle_stays_psel", 64'(PSEL), 64'h0);

        // ---------------- write with 3 wait states ----------------
        Transfer = 1'b1;
        IN_ADDR  = 32'h0000_1000;
        IN_DATA  = 32'h55;
        PREADY   = 1'b0;
        tick();                                   // SETUP
        chk("ww_setup_psel", 64'(PSEL), 64'h01);
        Transfer = 1'b0;
        tick();                                   // ACCESS
        IN_ADDR = 32'hFFFF_FFFF;
        IN_DATA = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ww_wait_penable", 64'(PENABLE), 64'h1);
            chk("ww_wait_paddr",   64'(PADDR),   64'h0000_1000);
            chk("ww_wait_pwdata",  64'(PWDATA),  64'h55);
            chk("ww_wait_psel",    64'(PSEL),    64'h01);
        end
        PREADY = 1'b1;
        tick();                                   // IDLE
        chk("ww_done_penable", 64'(PENABLE), 64'h0);
        chk("ww_done_psel",    64'(PSEL),    64'h0);

        // ---------------- reads ----------------
        Transfer = 1'b1;
        IN_WRITE = 1'b0;
        IN_ADDR  = 32'hBAB8_4CD3;
        IN_STRB  = 4'hF;
        PRDATA   = 32'h77;                        // ignored outside ACCESS
        PREADY   = 1'b1;
        tick();                                   // SETUP
        chk("r1_setup_pstrb",  64'(PSTRB),     64'h0);
        chk("r1_setup_pwrite", 64'(PWRITE),    64'h0);
        chk("r1_setup_rdata",  64'(OUT_RDATA), 64'h0);
        PRDATA = 32'd98;
        tick();                                   // ACCESS
        chk("r1_access_rdata", 64'(OUT_RDATA), 64'h0);
        chk("r1_access_penable", 64'(PENABLE), 64'h1);
        tick();                                   // SETUP of second read
        chk("r1_done_rdata",   64'(OUT_RDATA), 64'd98);
        chk("r1_done_penable", 64'(PENABLE),   64'h0);
        Transfer = 1'b0;
        PREADY   = 1'b0;
        PRDATA   = 32'd90;
        tick();                                   // ACCESS
        tick();                                   // wait state
        chk("r2_wait_rdata",   64'(OUT_RDATA), 64'd98);
        chk("r2_wait_penable", 64'(PENABLE),   64'h1);
        PREADY = 1'b1;
        tick();                                   // IDLE
        chk("r2_done_rdata",   64'(OUT_RDATA), 64'd90);
        chk("r2_done_penable", 64'(PENABLE),   64'h0);
        chk("r2_done_pstrb",   64'(PSTRB),     64'h0);

        // ---------------- slave error ----------------
        Transfer = 1'b1;
        IN_WRITE = 1'b1;
        PSLVERR  = 1'b1;                          // ignored in IDLE/SETUP
        tick();                                   // SETUP
        Transfer = 1'b0;
        tick();                                   // ACCESS
        chk("err_access_slverr", 64'(OUT_SLVERR), 64'h0);
        tick();                                   // IDLE
        chk("err_done_slverr", 64'(OUT_SLVERR), 64'h1);
        chk("err_write_rdata", 64'(OUT_RDATA),  64'd90);
        PSLVERR = 1'b0;

        // ---------------- reset during ACCESS ----------------
        Transfer = 1'b1;
        PREADY   = 1'b0;
        tick();                                   // SETUP
        tick();                                   // ACCESS
        chk("rst_pre_penable", 64'(PENABLE), 64'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        chk_all_zero("rst_held");
        Transfer = 1'b0;
        PRESETn  = 1'b1;
        tick();
        chk("rst_after_psel",    64'(PSEL),    64'h0);
        chk("rst_after_penable", 64'(PENABLE), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_master
`default_nettype wire
